// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with tree pseudo-LRU replacement.
// Optional hit/miss counters are compiled in when CACHE_PERF_CNT_EN is defined.
module cache_nway #(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    output logic         pmem_read,
    output logic         pmem_write
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 12 - IW;
    localparam int LW = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t state_q, state_d;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAYS-2:0]  plru_q  [SETS];
    logic [TW-1:0]    tag_q   [SETS][WAYS];
    logic [127:0]     data_q  [SETS][WAYS];

    logic [LW-1:0]    victim_q;
    logic [IW-1:0]    miss_idx_q;
    logic [TW-1:0]    miss_tag_q;

    logic             req;
    logic [IW-1:0]    req_idx;
    logic [TW-1:0]    req_tag;
    logic [2:0]       word_sel;
    logic             hit;
    logic [LW-1:0]    hit_way;
    logic [LW-1:0]    victim;
    logic             victim_dirty;
    logic [WAYS-2:0]  plru_upd;
    logic [127:0]     hit_line;
    logic [127:0]     merged_line;
    logic             idle_hit;
    logic             idle_miss;
    logic             fill_done;
    logic             unused_addr_bit;

    assign req      = mem_read | mem_write;
    assign req_idx  = mem_address[3+IW:4];
    assign req_tag  = mem_address[15:4+IW];
    assign word_sel = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];

    // Tag match across all ways, then victim selection (invalid way first, else PLRU walk).
    always_comb begin
        int ni;
        logic b;
        logic [LW-1:0] path;
        logic [LW-1:0] pv;
        logic          inv_found;
        logic [LW-1:0] inv_way;
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        pv        = '0;
        ni        = 0;
        b         = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = w[LW-1:0];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = w[LW-1:0];
            end
        end
        for (int l = 0; l < LW; l++) begin
            b     = plru_q[req_idx][ni[LW-1:0]];
            pv    = pv << 1;
            pv[0] = b;
            ni    = 2 * ni + 1 + int'(b);
        end
        victim       = inv_found ? inv_way : pv;
        victim_dirty = valid_q[req_idx][victim] && dirty_q[req_idx][victim];

        // Every tree bit on the hit way's path is flipped to point away from it.
        plru_upd = plru_q[req_idx];
        path     = hit_way;
        ni       = 0;
        for (int l = 0; l < LW; l++) begin
            b                    = path[LW-1];
            plru_upd[ni[LW-1:0]] = ~b;
            path                 = path << 1;
            ni                   = 2 * ni + 1 + int'(b);
        end
    end

    always_comb begin
        hit_line    = data_q[req_idx][hit_way];
        merged_line = hit_line;
        if (mem_byte_enable[0]) merged_line[{word_sel, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_line[{word_sel, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        idle_hit     = 1'b0;
        idle_miss    = 1'b0;
        fill_done    = 1'b0;
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {miss_tag_q, miss_idx_q, 4'h0};
        pmem_wdata   = data_q[miss_idx_q][victim_q];
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    idle_hit  = 1'b1;
                    mem_resp  = 1'b1;
                    mem_rdata = hit_line[{word_sel, 4'b0000} +: 16];
                end else if (req) begin
                    idle_miss = 1'b1;
                    state_d   = victim_dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[miss_idx_q][victim_q], miss_idx_q, 4'h0};
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Miss context is held so a dropped request still completes its fill.
    always_ff @(posedge clk) begin
        if (idle_miss) begin
            victim_q   <= victim;
            miss_idx_q <= req_idx;
            miss_tag_q <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (idle_hit) begin
                plru_q[req_idx] <= plru_upd;
                if (mem_write) dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[miss_idx_q][victim_q] <= 1'b1;
                dirty_q[miss_idx_q][victim_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (idle_hit && mem_write) data_q[req_idx][hit_way] <= merged_line;
        if (fill_done) begin
            data_q[miss_idx_q][victim_q] <= pmem_rdata;
            tag_q[miss_idx_q][victim_q]  <= miss_tag_q;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
    logic        retry_q;

    // retry_q marks a request that already missed, so its final hit is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
            retry_q    <= 1'b0;
        end else begin
            if (idle_miss) begin
                retry_q <= 1'b1;
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'h0001;
            end
            if (idle_hit) begin
                retry_q <= 1'b0;
                if (!retry_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'h0001;
            end
            if ((state_q == IDLE) && !req) retry_q <= 1'b0;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative, write-back, write-allocate cache for the LC-3b memory hierarchy. It sits between the CPU memory port (16-bit word, byte-enabled) and physical memory (128-bit line). It replaces the fixed 2-way cache with configurable associativity and set count, and adds:
- tree pseudo-LRU replacement,
- invalid-way-first victim choice,
- asynchronous reset that invalidates all state,
- optional performance counters.

## Interface
Parameters:
- WAYS, 2, associativity; power of two, 2..8
- SETS, 8, sets per way; power of two, 2..64; index bits IW = log2(SETS), tag bits = 12 − IW

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2  [1] high byte, [0] low byte of mem_wdata
- mem_address  in  16  byte address; [3:1] word offset, [3+IW:4] index, [15:4+IW] tag
- mem_wdata  in  16  write data
- mem_rdata  out  16  read data of hit word; 0 when no hit
- mem_resp  out  1  one-cycle completion pulse
- pmem_rdata  in  128  fill line
- pmem_resp  in  1  pmem transfer done
- pmem_address  out  16  line address, [3:0]=0
- pmem_wdata  out  128  victim line
- pmem_read  out  1  fill request
- pmem_write  out  1  writeback request

## Operation
- Storage per set and way: valid, dirty, tag, 128-bit data. Per set: WAYS−1 PLRU tree bits.
- Request = mem_read | mem_write. If both are asserted, the request is treated as a write.
- Lookup compares the tag against all valid ways. Exactly one way hits, or none.

FSM states: IDLE, WRITEBACK, FILL.
- IDLE, request, hit:
  - mem_resp=1 combinationally.
  - Write: merge enabled bytes into the hit word and set dirty.
  - Update PLRU toward the hit way on the clock edge.
  - Stay in IDLE.
- IDLE, request, miss:
  - Choose a victim: the lowest-index invalid way, otherwise the PLRU victim.
  - Latch the victim way. Go to WRITEBACK if the victim is valid and dirty, else FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 4'h0}, pmem_wdata=victim line.
  - On pmem_resp, go to FILL.
- FILL:
  - pmem_read=1, pmem_address={req tag, index, 4'h0}.
  - On pmem_resp, write pmem_rdata into the victim way with tag=req tag, valid=1, dirty=0, then go to IDLE.
  - The retried lookup then hits.
- PLRU: a binary tree, root bit 0. On each access, every bit on the accessed way's path is set to point away from it. The victim is found by following the bits from the root.
- A request dropped mid-miss still completes the fill. No mem_resp is produced for it.
- pmem_read and pmem_write are never both high.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - state → IDLE;
  - all valid, dirty and PLRU bits;
  - pmem_read = pmem_write = mem_resp = 0 and mem_rdata = 0, immediately.
  - Tags and data need not be cleared.
- Hit latency: mem_resp is asserted in the cycle the request is presented (0 wait cycles).
- Clean miss: FILL is entered the next cycle. mem_resp comes 1 cycle after the pmem_resp of the fill.
- Dirty miss: WRITEBACK, then FILL, then IDLE hit.
- pmem_address, pmem_wdata and the pmem strobes are stable from state entry until pmem_resp.
- Reset asserted mid-WRITEBACK or mid-FILL drops the strobes in the same cycle. The line being filled is not validated.

## Configuration
- CACHE_PERF_CNT_EN defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0], saturating at 16'hFFFF and reset to 0.
  - hit_count increments on a mem_resp whose request hit on its first lookup.
  - miss_count increments once per request entering WRITEBACK or FILL from IDLE.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- After reset, with WAYS=2, SETS=8:
  - read 0x0046 → pmem_read with pmem_address=0x0040;
  - return a line with word3=0x1234 → mem_resp with mem_rdata=0x1234;
  - pmem_write is never asserted.
- Write 0x0046, mem_wdata=0xABCD, byte_enable=2'b01 → hit with 0 waits. A subsequent read of 0x0046 returns 0x12CD.
- Dirty eviction in set 4, WAYS=2:
  - read 0x0040;
  - write 0x00C2 with 0x5555, byte_enable=2'b11;
  - read 0x0040;
  - read 0x0140 → pmem_write at 0x00C0 with word1=0x5555, then pmem_read at 0x0140; way0 still holds 0x0040.
- WAYS=4, same set:
  - fill A,B,C,D, then hit A;
  - then miss E → C's way is the victim, and A, B, D still hit.
- Pull rst_n low while pmem_read=1 → pmem_read=0 in the same cycle. The next read of the same address misses and issues pmem_read again.
- CACHE_PERF_CNT_EN defined, scenario 1 then scenario 2 → miss_count=1, hit_count=1.
